rle_stream_decompress: RTL
==========================

Name: rle_stream_decompress

Overview:
- Clocked, parametrised successor to the combinational decompressor in the DCNN IO path.
- Consumes a stream of run-length tokens (bit value, run length) from the compressed-weight fetch path.
- Packs the expanded bits LSB-first into OUT_W-bit words and emits them over a valid/ready handshake to the weight buffer.
- Reports word index (byteIndx), bit fill position (bitIndx) and completion (done).

Parameters:
- OUT_W, 8, output word width in bits (power of 2, ≥4).
- CNT_W, 8, token run-length field width; run length = tok_len+1.
- IDX_W, 32, width of byteIndx and total_words.
- BIT_W, $clog2(OUT_W)+1, width of bitIndx (must represent OUT_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- work  in  1  start request, sampled in IDLE/DONE.
- total_words  in  IDX_W  number of words to produce, sampled when work is accepted.
- tok_valid  in  1  token valid.
- tok_ready  out  1  token accepted when tok_valid&&tok_ready.
- tok_bit  in  1  run bit value.
- tok_len  in  CNT_W  run length minus 1.
- tok_last  in  1  final token of stream.
- out_valid  out  1  word valid.
- out_ready  in  1  downstream accepts word.
- out  out  OUT_W  packed word.
- byteIndx  out  IDX_W  index of the current/emitted word.
- bitIndx  out  BIT_W  bits filled in the current word.
- done  out  1  stream complete.
- overrun  out  1  run bits were discarded at completion.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; out, byteIndx, bitIndx, run_rem, done, overrun, out_valid, tok_ready all 0. This applies from any state, including mid-run; partial words are lost.
- IDLE/DONE, work=1:
  - If total_words==0: go to DONE, with done=1 on the next cycle.
  - Otherwise: clear out, byteIndx, bitIndx, done and overrun, latch total_words, go to FETCH.
- work in any other state is ignored.
- FETCH: tok_ready=1 (registered, asserted on state entry). On handshake: latch tok_bit and tok_last, set run_rem=tok_len+1 (CNT_W+1 bits), go to FILL.
- FILL: one chunk per cycle.
  - k = min(run_rem, OUT_W-bitIndx).
  - out bits [bitIndx, bitIndx+k) are set to tok_bit.
  - bitIndx += k; run_rem -= k.
  - If the new bitIndx==OUT_W: go to EMIT.
  - Else if run_rem reaches 0 and the token was last: go to EMIT (partial word, upper bits 0).
  - Else if run_rem reaches 0: go to FETCH.
- EMIT:
  - out_valid=1; out, byteIndx and bitIndx are held stable while out_ready=0.
  - On out_ready: byteIndx+=1, bitIndx=0, out cleared.
  - If the new byteIndx==total_words, or (run_rem==0 and the last token has been consumed): go to DONE. overrun=run_rem!=0 || !last_seen.
  - Else if run_rem>0: go to FILL.
  - Else: go to FETCH.
- DONE: done=1 and byteIndx held until work restarts or reset. tok_ready=0 and out_valid=0.
- A run may span multiple words; a run bit never crosses into a word after total_words.
- Throughput is one chunk per cycle. Latency from accepted token to first possible out_valid is 2 cycles (FILL, then EMIT).
- Arithmetic:
  - byteIndx wraps modulo 2^IDX_W; no saturation.
  - run_rem is CNT_W+1 bits, so tok_len all-ones gives 2^CNT_W without overflow.

Decomposition:
- Shared package dcnn_io_pkg holds:
  - the state enum {IDLE, FETCH, FILL, EMIT, DONE};
  - localparam helpers for BIT_W;
  - a token struct {bit, len, last}.
- One sub-module, rle_fill_mask: combinational, inputs start position and k, output OUT_W-bit mask of k ones starting at start. It is shared with the future multi-channel variant.

Test Plan:
1. OUT_W=8, total_words=2; tokens (1,len=3),(0,len=11,last) -> out=0x0F with byteIndx=0, bitIndx=8; then out=0x00 with byteIndx=1; then done=1, overrun=0.
2. total_words=2; single token (1,len=19) -> two words 0xFF, 0xFF; done=1, overrun=1 (4 bits discarded); tok_ready stays 0 afterwards.
3. total_words=4; token (1,len=2,last) -> one word out=0x07 with bitIndx=3; then done=1, final byteIndx=1, overrun=0.
4. Hold out_ready=0 for 5 cycles in EMIT -> out, byteIndx, bitIndx and out_valid stay stable; tok_ready=0; no token consumed; progress resumes the cycle after out_ready=1.
5. Drive rst_n=0 for one cycle mid-FILL -> next cycle all outputs 0 and state IDLE; a following work restart produces correct words from byteIndx=0.
6. total_words=0 with work=1 -> done=1 on the next cycle; tok_ready never asserted; out_valid never asserted.

Source files
------------

// File: rtl/dcnn_io_pkg.sv
// Shared types for the DCNN IO path.
//   state_e : control states of the run-length stream decompressor.
//   tok_t   : one run-length token (run bit value, run length minus 1, last flag).
//   bit_w() : width needed to hold a bit position 0..out_w inclusive.
package dcnn_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FILL,
        EMIT,
        DONE
    } state_e;

    // Run-length field width of the standard compressed-weight token.
    localparam int TOK_LEN_W = 8;

    typedef struct packed {
        logic                 value;
        logic [TOK_LEN_W-1:0] len;
        logic                 last;
    } tok_t;

    // A fill position must be able to hold out_w itself (word full).
    function automatic int bit_w(input int out_w);
        return $clog2(out_w) + 1;
    endfunction

endpackage

// File: rtl/rle_fill_mask.sv
// Combinational run mask: sets len consecutive bits of an OUT_W-bit word,
// starting at bit position start. Bits at or beyond OUT_W are dropped.
// Ports:
//   start  in  BIT_W  first bit position to set
//   len    in  BIT_W  number of bits to set
//   mask   out OUT_W  resulting mask
module rle_fill_mask #(
    parameter int OUT_W = 8,
    parameter int BIT_W = 4
) (
    input  logic [BIT_W-1:0] start,
    input  logic [BIT_W-1:0] len,
    output logic [OUT_W-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < OUT_W; i++) begin
            mask[i] = (i >= int'(start)) && (i < int'(start) + int'(len));
        end
    end

endmodule

// File: rtl/rle_stream_decompress.sv
// Run-length stream decompressor. Expands (bit, length) tokens into a bit
// stream, packs it LSB-first into OUT_W-bit words and hands the words to the
// weight buffer over a valid/ready handshake.
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   work, total_words start request and number of words to produce
//   tok_valid/ready   token handshake; tok_bit, tok_len (length-1), tok_last
//   out_valid/ready   word handshake; out is the packed word
//   byteIndx, bitIndx index of the current word and bits filled in it
//   done, overrun     stream complete; run bits were discarded at completion
module rle_stream_decompress
    import dcnn_io_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int CNT_W = 8,
    parameter int IDX_W = 32,
    parameter int BIT_W = bit_w(OUT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             work,
    input  logic [IDX_W-1:0] total_words,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_bit,
    input  logic [CNT_W-1:0] tok_len,
    input  logic             tok_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic [IDX_W-1:0] byteIndx,
    output logic [BIT_W-1:0] bitIndx,
    output logic             done,
    output logic             overrun
);

    // One extra bit so that tok_len all-ones (2^CNT_W bits) fits.
    localparam int RW = CNT_W + 1;

    state_e           state, state_n;
    logic [RW-1:0]    run_rem, run_rem_n;
    logic [IDX_W-1:0] total_q, total_n;
    logic [IDX_W-1:0] byte_n, byte_inc;
    logic [OUT_W-1:0] out_n, fill_mask;
    logic [BIT_W-1:0] bit_n, k_bits;
    logic [RW-1:0]    space, k;
    logic             cur_bit, cur_bit_n;
    logic             last_seen, last_seen_n;
    logic             overrun_n;

    // Chunk size for this cycle: the rest of the run or the rest of the word.
    assign space  = RW'(OUT_W) - RW'(bitIndx);
    assign k      = (run_rem < space) ? run_rem : space;
    assign k_bits = BIT_W'(k);

    assign byte_inc = byteIndx + IDX_W'(1);

    rle_fill_mask #(
        .OUT_W(OUT_W),
        .BIT_W(BIT_W)
    ) u_fill_mask (
        .start(bitIndx),
        .len  (k_bits),
        .mask (fill_mask)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_n     = state;
        out_n       = out;
        byte_n      = byteIndx;
        bit_n       = bitIndx;
        run_rem_n   = run_rem;
        total_n     = total_q;
        cur_bit_n   = cur_bit;
        last_seen_n = last_seen;
        overrun_n   = overrun;

        unique case (state)
            IDLE, DONE: begin
                if (work) begin
                    if (total_words == '0) begin
                        state_n = DONE;
                    end else begin
                        out_n       = '0;
                        byte_n      = '0;
                        bit_n       = '0;
                        run_rem_n   = '0;
                        overrun_n   = 1'b0;
                        last_seen_n = 1'b0;
                        total_n     = total_words;
                        state_n     = FETCH;
                    end
                end
            end

            FETCH: begin
                if (tok_valid && tok_ready) begin
                    cur_bit_n   = tok_bit;
                    last_seen_n = tok_last;
                    run_rem_n   = RW'(tok_len) + RW'(1);
                    state_n     = FILL;
                end
            end

            FILL: begin
                // Bits above bitIndx are still zero, so clearing for a 0-run
                // only keeps the intent explicit.
                out_n     = cur_bit ? (out | fill_mask) : (out & ~fill_mask);
                bit_n     = bitIndx + k_bits;
                run_rem_n = run_rem - k;
                if (bit_n == BIT_W'(OUT_W)) begin
                    state_n = EMIT;
                end else if (run_rem_n == '0) begin
                    state_n = last_seen ? EMIT : FETCH;
                end
            end

            EMIT: begin
                if (out_ready) begin
                    byte_n = byte_inc;
                    bit_n  = '0;
                    out_n  = '0;
                    if (byte_inc == total_q || (run_rem == '0 && last_seen)) begin
                        state_n   = DONE;
                        overrun_n = (run_rem != '0) || !last_seen;
                    end else if (run_rem != '0) begin
                        state_n = FILL;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Handshake and status outputs are registered from the next state so
    // they rise on the same edge that enters the corresponding state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            byteIndx  <= '0;
            bitIndx   <= '0;
            run_rem   <= '0;
            total_q   <= '0;
            cur_bit   <= 1'b0;
            last_seen <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            tok_ready <= 1'b0;
        end else begin
            state     <= state_n;
            out       <= out_n;
            byteIndx  <= byte_n;
            bitIndx   <= bit_n;
            run_rem   <= run_rem_n;
            total_q   <= total_n;
            cur_bit   <= cur_bit_n;
            last_seen <= last_seen_n;
            done      <= (state_n == DONE);
            overrun   <= overrun_n;
            out_valid <= (state_n == EMIT);
            tok_ready <= (state_n == FETCH);
        end
    end

endmodule
